// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates an entry per issued instruction and retires
// entries in program order. A committed branch mispredict flushes the machine.
module reorder_buffer #(
    parameter int RoB_addr = 3
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                issue_valid,
    input  logic [1:0]          issue_type,
    input  logic [4:0]          issue_rd,
    input  logic                issue_pred_taken,
    input  logic [31:0]         issue_alt_pc,
    output logic [RoB_addr-1:0] issue_tag,
    output logic                full,
    output logic                rf_issue_valid,
    output logic [4:0]          rf_issue_index,
    output logic [RoB_addr-1:0] rf_new_dep,
    input  logic                wb_valid,
    input  logic [RoB_addr-1:0] wb_tag,
    input  logic [31:0]         wb_value,
    input  logic                wb_taken,
    input  logic [RoB_addr-1:0] q1_tag,
    input  logic [RoB_addr-1:0] q2_tag,
    output logic                q1_ready,
    output logic                q2_ready,
    output logic [31:0]         q1_value,
    output logic [31:0]         q2_value,
    output logic                commit_valid,
    output logic [4:0]          commit_regid,
    output logic [31:0]         commit_value,
    output logic [RoB_addr-1:0] commit_tag,
    output logic                store_commit_valid,
    output logic [RoB_addr-1:0] store_commit_tag,
    output logic                rf_clear,
    output logic [31:0]         redirect_pc,
    output logic [RoB_addr:0]   dbg_count
);
    localparam int DEPTH = 1 << RoB_addr;
    localparam logic [RoB_addr:0] FULL_COUNT = (RoB_addr+1)'(DEPTH);
    localparam logic [1:0] T_REG = 2'd0;
    localparam logic [1:0] T_BR  = 2'd1;
    localparam logic [1:0] T_ST  = 2'd2;

    logic [DEPTH-1:0]    busy, ready, pred_taken, taken;
    logic [1:0]          e_type   [DEPTH];
    logic [4:0]          e_rd     [DEPTH];
    logic [31:0]         e_value  [DEPTH];
    logic [31:0]         e_alt_pc [DEPTH];
    logic [RoB_addr-1:0] head, tail;
    logic [RoB_addr:0]   count;

    logic       accept, pop, mispredict, wb_hit;
    logic       q1_wb, q2_wb;
    logic [1:0] issue_kind;

    // Issue handshake: an instruction transfers on a rising edge where issue_valid,
    // rdy_in are high and full is low; otherwise the decoder holds it unchanged.
    always_comb begin
        full           = (count == FULL_COUNT) | rf_clear;
        accept         = issue_valid & ~full & rdy_in;
        pop            = rdy_in & ~rf_clear & busy[head] & ready[head];
        mispredict     = pop & (e_type[head] == T_BR) & (taken[head] != pred_taken[head]);
        wb_hit         = rdy_in & ~rf_clear & wb_valid & busy[wb_tag];
        issue_kind     = (issue_type == 2'd3) ? T_REG : issue_type;
        issue_tag      = tail;
        rf_issue_valid = accept;
        rf_issue_index = issue_rd;
        rf_new_dep     = tail;
        dbg_count      = count;
    end

    // Operand lookup forwards from the CDB when the tag is being written this cycle.
    always_comb begin
        q1_wb    = wb_valid & (wb_tag == q1_tag);
        q2_wb    = wb_valid & (wb_tag == q2_tag);
        q1_ready = ready[q1_tag] | q1_wb;
        q2_ready = ready[q2_tag] | q2_wb;
        q1_value = q1_wb ? wb_value : e_value[q1_tag];
        q2_value = q2_wb ? wb_value : e_value[q2_tag];
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head               <= '0;
            tail               <= '0;
            count              <= '0;
            busy               <= '0;
            ready              <= '0;
            pred_taken         <= '0;
            taken              <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                e_type[i]   <= T_REG;
                e_rd[i]     <= '0;
                e_value[i]  <= '0;
                e_alt_pc[i] <= '0;
            end
            commit_valid       <= 1'b0;
            commit_regid       <= '0;
            commit_value       <= '0;
            commit_tag         <= '0;
            store_commit_valid <= 1'b0;
            store_commit_tag   <= '0;
            rf_clear           <= 1'b0;
            redirect_pc        <= '0;
        end else begin
            commit_valid       <= 1'b0;
            store_commit_valid <= 1'b0;
            rf_clear           <= 1'b0;

            if (accept) begin
                busy[tail]       <= 1'b1;
                ready[tail]      <= 1'b0;
                taken[tail]      <= 1'b0;
                pred_taken[tail] <= issue_pred_taken;
                e_type[tail]     <= issue_kind;
                e_rd[tail]       <= issue_rd;
                e_alt_pc[tail]   <= issue_alt_pc;
                tail             <= tail + 1'b1;
            end

            if (wb_hit) begin
                ready[wb_tag]   <= 1'b1;
                e_value[wb_tag] <= wb_value;
                taken[wb_tag]   <= wb_taken;
            end

            if (pop) begin
                busy[head] <= 1'b0;
                head       <= head + 1'b1;
                if (e_type[head] == T_ST) begin
                    store_commit_valid <= 1'b1;
                    store_commit_tag   <= head;
                end else if (e_type[head] == T_REG) begin
                    commit_valid <= 1'b1;
                    commit_regid <= e_rd[head];
                    commit_value <= e_value[head];
                    commit_tag   <= head;
                end
            end

            // A mispredict overrides the allocation and pop made on the same edge.
            if (mispredict) begin
                busy        <= '0;
                ready       <= '0;
                head        <= '0;
                tail        <= '0;
                count       <= '0;
                rf_clear    <= 1'b1;
                redirect_pc <= e_alt_pc[head];
            end else if (accept & ~pop) begin
                count <= count + 1'b1;
            end else if (pop & ~accept) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: program-order queue model checked every cycle,
// plus literal expectations taken from hand-worked scenarios.
module tb_reorder_buffer;
    localparam int DEPTH = 8;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        issue_valid, issue_pred_taken;
    logic [1:0]  issue_type;
    logic [4:0]  issue_rd;
    logic [31:0] issue_alt_pc;
    logic [2:0]  issue_tag;
    logic        full, rf_issue_valid;
    logic [4:0]  rf_issue_index;
    logic [2:0]  rf_new_dep;
    logic        wb_valid, wb_taken;
    logic [2:0]  wb_tag;
    logic [31:0] wb_value;
    logic [2:0]  q1_tag, q2_tag;
    logic        q1_ready, q2_ready;
    logic [31:0] q1_value, q2_value;
    logic        commit_valid;
    logic [4:0]  commit_regid;
    logic [31:0] commit_value;
    logic [2:0]  commit_tag;
    logic        store_commit_valid;
    logic [2:0]  store_commit_tag;
    logic        rf_clear;
    logic [31:0] redirect_pc;
    logic [3:0]  dbg_count;

    always #5 clk_in = ~clk_in;

    reorder_buffer #(.RoB_addr(3)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
        .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
        .issue_tag(issue_tag), .full(full),
        .rf_issue_valid(rf_issue_valid), .rf_issue_index(rf_issue_index), .rf_new_dep(rf_new_dep),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value), .wb_taken(wb_taken),
        .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
        .q1_value(q1_value), .q2_value(q2_value),
        .commit_valid(commit_valid), .commit_regid(commit_regid),
        .commit_value(commit_value), .commit_tag(commit_tag),
        .store_commit_valid(store_commit_valid), .store_commit_tag(store_commit_tag),
        .rf_clear(rf_clear), .redirect_pc(redirect_pc), .dbg_count(dbg_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: expected in-flight instructions, oldest first.
    typedef struct packed {
        logic [2:0]  tag;
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic        rdy;
        logic [31:0] val;
        logic        tkn;
        logic        pred;
        logic [31:0] alt;
    } ent_t;

    ent_t        exp_q[$];
    int          m_next  = 0;
    logic        m_cv    = 1'b0;
    logic [4:0]  m_regid = '0;
    logic [31:0] m_val   = '0;
    logic [2:0]  m_ctag  = '0;
    logic        m_sv    = 1'b0;
    logic [2:0]  m_stag  = '0;
    logic        m_clr   = 1'b0;
    logic [31:0] m_pc    = '0;

    always @(posedge clk_in or negedge rst_in) begin : model
        ent_t e;
        logic was_clr, acc, pop, flush;
        if (!rst_in) begin
            exp_q.delete();
            m_next = 0; m_cv = 0; m_regid = 0; m_val = 0; m_ctag = 0;
            m_sv = 0; m_stag = 0; m_clr = 0; m_pc = 0;
        end else begin
            was_clr = m_clr;
            m_cv = 0; m_sv = 0; m_clr = 0;
            if (rdy_in && !was_clr) begin
                acc   = issue_valid && (exp_q.size() < DEPTH);
                pop   = (exp_q.size() > 0) && exp_q[0].rdy;
                flush = 1'b0;
                if (pop) begin
                    e = exp_q.pop_front();
                    if (e.kind == 2'd2) begin
                        m_sv = 1; m_stag = e.tag;
                    end else if (e.kind == 2'd1) begin
                        flush = (e.tkn != e.pred);
                    end else begin
                        m_cv = 1; m_regid = e.rd; m_val = e.val; m_ctag = e.tag;
                    end
                end
                if (flush) begin
                    exp_q.delete();
                    m_next = 0; m_clr = 1; m_pc = e.alt;
                end else begin
                    if (wb_valid)
                        foreach (exp_q[i])
                            if (exp_q[i].tag == wb_tag) begin
                                exp_q[i].rdy = 1'b1;
                                exp_q[i].val = wb_value;
                                exp_q[i].tkn = wb_taken;
                            end
                    if (acc) begin
                        e.tag  = m_next[2:0];
                        e.kind = (issue_type == 2'd3) ? 2'd0 : issue_type;
                        e.rd   = issue_rd;
                        e.rdy  = 1'b0;
                        e.val  = '0;
                        e.tkn  = 1'b0;
                        e.pred = issue_pred_taken;
                        e.alt  = issue_alt_pc;
                        exp_q.push_back(e);
                        m_next = (m_next + 1) % DEPTH;
                    end
                end
            end
        end
    end

    task automatic check_lookup(input string name, input logic [2:0] tag,
                                input logic act_rdy, input logic [31:0] act_val);
        if (wb_valid && wb_tag == tag) begin
            check({name, "_rdy"}, act_rdy, 1);
            check({name, "_val"}, act_val, wb_value);
        end else begin
            foreach (exp_q[i])
                if (exp_q[i].tag == tag) begin
                    check({name, "_rdy"}, act_rdy, exp_q[i].rdy);
                    if (exp_q[i].rdy) check({name, "_val"}, act_val, exp_q[i].val);
                end
        end
    endtask

    always @(negedge clk_in) begin : compare
        logic exp_full, exp_acc;
        exp_full = (exp_q.size() == DEPTH) || m_clr;
        exp_acc  = issue_valid && !exp_full && rdy_in;
        check("full", full, exp_full);
        check("issue_tag", issue_tag, m_next);
        check("rf_new_dep", rf_new_dep, m_next);
        check("rf_issue_valid", rf_issue_valid, exp_acc);
        check("rf_issue_index", rf_issue_index, issue_rd);
        check("count", dbg_count, exp_q.size());
        check("commit_valid", commit_valid, m_cv);
        check("commit_regid", commit_regid, m_regid);
        check("commit_value", commit_value, m_val);
        check("commit_tag", commit_tag, m_ctag);
        check("store_valid", store_commit_valid, m_sv);
        check("store_tag", store_commit_tag, m_stag);
        check("rf_clear", rf_clear, m_clr);
        check("redirect_pc", redirect_pc, m_pc);
        check_lookup("q1", q1_tag, q1_ready, q1_value);
        check_lookup("q2", q2_tag, q2_ready, q2_value);
    end

    task automatic cycle();
        @(posedge clk_in);
        #1;
        issue_valid = 1'b0;
        wb_valid    = 1'b0;
    endtask

    task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic pred, input logic [31:0] alt);
        issue_valid = 1'b1; issue_type = t; issue_rd = rd;
        issue_pred_taken = pred; issue_alt_pc = alt;
    endtask

    task automatic wb(input logic [2:0] tag, input logic [31:0] v, input logic tk);
        wb_valid = 1'b1; wb_tag = tag; wb_value = v; wb_taken = tk;
    endtask

    task automatic apply_reset();
        rst_in = 1'b0; issue_valid = 1'b0; wb_valid = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
    endtask

    initial begin
        rdy_in = 1'b1; issue_valid = 0; issue_type = 0; issue_rd = 0;
        issue_pred_taken = 0; issue_alt_pc = 0;
        wb_valid = 0; wb_tag = 0; wb_value = 0; wb_taken = 0;
        q1_tag = 0; q2_tag = 0;
        apply_reset();
        check("rst_issue_tag", issue_tag, 0);
        check("rst_full", full, 0);
        check("rst_count", dbg_count, 0);
        check("rst_rf_clear", rf_clear, 0);
        check("rst_redirect", redirect_pc, 0);

        // In-order allocation
        issue(0, 5, 0, 0); #2; check("t1_tag0", issue_tag, 0); check("t1_dep0", rf_new_dep, 0); cycle();
        issue(0, 6, 0, 0); #2; check("t1_tag1", issue_tag, 1); check("t1_dep1", rf_new_dep, 1); cycle();
        issue(0, 7, 0, 0); #2; check("t1_tag2", issue_tag, 2); check("t1_idx2", rf_issue_index, 7); cycle();
        check("t1_count", dbg_count, 3);

        // Out-of-order writeback, in-order commit
        wb(1, 32'h22, 0); cycle();
        wb(0, 32'h11, 0); cycle();
        check("t2_no_commit_yet", commit_valid, 0);
        cycle();
        check("t2_c0_valid", commit_valid, 1); check("t2_c0_tag", commit_tag, 0);
        check("t2_c0_reg", commit_regid, 5); check("t2_c0_val", commit_value, 32'h11);
        cycle();
        check("t2_c1_valid", commit_valid, 1); check("t2_c1_tag", commit_tag, 1);
        check("t2_c1_reg", commit_regid, 6); check("t2_c1_val", commit_value, 32'h22);
        cycle();
        check("t2_pulse_end", commit_valid, 0); check("t2_count", dbg_count, 1);

        // Full buffer, wrap-around
        apply_reset();
        for (int i = 0; i < 8; i++) begin issue(0, 5'(i + 1), 0, 0); cycle(); end
        check("t3_full", full, 1); check("t3_count", dbg_count, 8);
        issue(0, 9, 0, 0); wb(0, 32'hA0, 0); #2; check("t3_held", rf_issue_valid, 0); cycle();
        issue(0, 9, 0, 0); #2; check("t3_full_pop_cycle", full, 1); check("t3_held2", rf_issue_valid, 0); cycle();
        check("t3_pop", commit_valid, 1); check("t3_pop_tag", commit_tag, 0); check("t3_free", full, 0);
        issue(0, 9, 0, 0); #2; check("t3_wrap_tag", issue_tag, 0); check("t3_accept", rf_issue_valid, 1); cycle();
        check("t3_refull", full, 1);

        // Store commit and branch mispredict flush
        apply_reset();
        issue(2, 0, 0, 0); cycle();
        issue(1, 0, 0, 32'h1000); cycle();
        issue(0, 10, 0, 0); cycle();
        issue(0, 11, 0, 0); cycle();
        wb(0, 32'h0, 0); cycle();
        wb(2, 32'h55, 0); cycle();
        check("t4_store", store_commit_valid, 1); check("t4_store_tag", store_commit_tag, 0);
        check("t4_store_no_rf", commit_valid, 0);
        wb(3, 32'h66, 0); cycle();
        wb(1, 32'h0, 1); cycle();
        issue(0, 13, 0, 0); cycle();
        check("t4_clear", rf_clear, 1); check("t4_redirect", redirect_pc, 32'h1000);
        check("t4_flush_count", dbg_count, 0); check("t4_flush_full", full, 1);
        issue(0, 14, 0, 0); wb(2, 32'h99, 0); #2; check("t4_no_issue_in_flush", rf_issue_valid, 0); cycle();
        check("t4_clear_pulse", rf_clear, 0); check("t4_young_dropped", commit_valid, 0);
        check("t4_count_after", dbg_count, 0);
        issue(0, 12, 0, 0); #2; check("t4_resume_tag", issue_tag, 0); cycle();

        // Lookup with CDB forwarding
        issue(1, 0, 1, 32'h2000); cycle();
        issue(0, 20, 0, 0); cycle();
        issue(3, 21, 0, 0); cycle();
        q1_tag = 3; q2_tag = 0; wb(3, 32'hABCD, 0); #2;
        check("t5_q1_rdy", q1_ready, 1); check("t5_q1_val", q1_value, 32'hABCD);
        check("t5_q2_notrdy", q2_ready, 0);
        cycle();
        q2_tag = 3; #2;
        check("t5_q2_rdy", q2_ready, 1); check("t5_q2_val", q2_value, 32'hABCD);

        // Global enable freeze, correct branch, async reset
        wb(0, 32'h77, 0); cycle();
        rdy_in = 1'b0; issue(0, 22, 0, 0); #2; check("t6_frozen_issue", rf_issue_valid, 0);
        cycle();
        check("t6_frozen_commit", commit_valid, 0); check("t6_frozen_count", dbg_count, 4);
        check("t6_frozen_tail", issue_tag, 4);
        cycle();
        check("t6_frozen_commit2", commit_valid, 0);
        rdy_in = 1'b1; cycle();
        check("t6_resume", commit_valid, 1); check("t6_resume_reg", commit_regid, 12);
        check("t6_resume_val", commit_value, 32'h77);
        wb(1, 32'h0, 1); cycle();
        wb(2, 32'h44, 0); cycle();
        check("t6_good_br", commit_valid, 0); check("t6_good_br_clr", rf_clear, 0);
        check("t6_good_br_count", dbg_count, 2);
        cycle();
        check("t6_c2_reg", commit_regid, 20); check("t6_c2_val", commit_value, 32'h44);
        cycle();
        check("t6_type3_valid", commit_valid, 1); check("t6_type3_reg", commit_regid, 21);
        check("t6_type3_tag", commit_tag, 3);
        rst_in = 1'b0; #1;
        check("t6_arst_valid", commit_valid, 0); check("t6_arst_val", commit_value, 0);
        check("t6_arst_reg", commit_regid, 0); check("t6_arst_count", dbg_count, 0);
        check("t6_arst_tag", issue_tag, 0);
        repeat (2) @(posedge clk_in);
        #1; rst_in = 1'b1;
        cycle();
        check("t6_after_rst", dbg_count, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
